// File: rtl/parking_spot_unit.sv
// Single parking spot: park-in animation, PIN-checked pickup, billing hand-off and drive-out
// animation, with a free-running 9-bit tick counter for time stamps.
module parking_spot_unit #(
  parameter int unsigned ANIM_TICKS = 10
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       tick,
  input  logic       car_in,
  input  logic       attempt,
  input  logic       leave,
  input  logic [2:0] vehicle_size,
  input  logic [3:0] pin,
  output logic       occupied,
  output logic [8:0] start_time,
  output logic [8:0] final_time,
  output logic       calculate_fare,
  output logic [9:0] light,
  output logic [2:0] vehicle_size_out,
  output logic       password_correct,
  output logic       car_in_done,
  output logic       pin_error
);

  typedef enum logic [2:0] {
    StEmpty,
    StParking,
    StOccupied,
    StBilling,
    StDeparting
  } state_e;

  localparam logic [3:0] AnimLast = 4'(ANIM_TICKS - 1);

  state_e     state_q, state_d;
  logic [8:0] time_q, time_d;
  logic [3:0] anim_q, anim_d;
  logic [8:0] start_q, start_d;
  logic [8:0] final_q, final_d;
  logic [9:0] light_q, light_d;
  logic [2:0] vsize_q, vsize_d;
  logic [3:0] pin_q, pin_d;
  logic       pw_q, pw_d;
  logic       done_q, done_d;
  logic       perr_q, perr_d;
  logic       fare_q, fare_d;
  logic       size_ok;

  assign size_ok = (vehicle_size == 3'b001) || (vehicle_size == 3'b010) ||
                   (vehicle_size == 3'b100);

  always_comb begin
    state_d = state_q;
    time_d  = tick ? time_q + 9'd1 : time_q;
    anim_d  = anim_q;
    start_d = start_q;
    final_d = final_q;
    light_d = light_q;
    vsize_d = vsize_q;
    pin_d   = pin_q;
    pw_d    = pw_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    fare_d  = 1'b0;

    case (state_q)
      StEmpty: begin
        light_d = '0;
        if (car_in && size_ok) begin
          // Time stamps use the counter value before this cycle's tick.
          vsize_d = vehicle_size;
          pin_d   = pin;
          start_d = time_q;
          anim_d  = '0;
          light_d = 10'h001;
          state_d = StParking;
        end
      end
      StParking: begin
        if (tick) begin
          if (anim_q == AnimLast) begin
            state_d = StOccupied;
            done_d  = 1'b1;
            light_d = 10'h3FF;
          end else begin
            anim_d  = anim_q + 4'd1;
            light_d = {light_q[8:0], light_q[9]};
          end
        end
      end
      StOccupied: begin
        light_d = 10'h3FF;
        if (attempt) begin
          if (pin == pin_q) begin
            final_d = time_q;
            pw_d    = 1'b1;
            fare_d  = 1'b1;
            light_d = 10'h155;
            state_d = StBilling;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      StBilling: begin
        light_d = 10'h155;
        if (leave) begin
          anim_d  = '0;
          light_d = 10'h200;
          state_d = StDeparting;
        end
      end
      StDeparting: begin
        if (tick) begin
          if (anim_q == AnimLast) begin
            state_d = StEmpty;
            light_d = '0;
            pw_d    = 1'b0;
            vsize_d = '0;
          end else begin
            anim_d  = anim_q + 4'd1;
            light_d = {light_q[0], light_q[9:1]};
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StEmpty;
      time_q  <= '0;
      anim_q  <= '0;
      start_q <= '0;
      final_q <= '0;
      light_q <= '0;
      vsize_q <= '0;
      pin_q   <= '0;
      pw_q    <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      fare_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      anim_q  <= anim_d;
      start_q <= start_d;
      final_q <= final_d;
      light_q <= light_d;
      vsize_q <= vsize_d;
      pin_q   <= pin_d;
      pw_q    <= pw_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      fare_q  <= fare_d;
    end
  end

  assign occupied         = (state_q != StEmpty);
  assign start_time       = start_q;
  assign final_time       = final_q;
  assign calculate_fare   = fare_q;
  assign light            = light_q;
  assign vehicle_size_out = vsize_q;
  assign password_correct = pw_q;
  assign car_in_done      = done_q;
  assign pin_error        = perr_q;

endmodule

// File: tb/tb_parking_spot_unit.sv
// Self-checking bench for parking_spot_unit: vector table plus hand sequences, all checks
// routed through an expectation queue drained one clock after each stimulus.
module tb_parking_spot_unit;

  logic       clock = 1'b0;
  logic       resetn;
  logic       tick, car_in, attempt, leave;
  logic [2:0] vehicle_size;
  logic [3:0] pin;
  logic       occupied, calculate_fare, password_correct, car_in_done, pin_error;
  logic [8:0] start_time, final_time;
  logic [9:0] light;
  logic [2:0] vehicle_size_out;

  int n_vec = 0;
  int n_err = 0;

  parking_spot_unit #(.ANIM_TICKS(10)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .tick            (tick),
    .car_in          (car_in),
    .attempt         (attempt),
    .leave           (leave),
    .vehicle_size    (vehicle_size),
    .pin             (pin),
    .occupied        (occupied),
    .start_time      (start_time),
    .final_time      (final_time),
    .calculate_fare  (calculate_fare),
    .light           (light),
    .vehicle_size_out(vehicle_size_out),
    .password_correct(password_correct),
    .car_in_done     (car_in_done),
    .pin_error       (pin_error)
  );

  always #5 clock = ~clock;

  typedef enum int {SOcc, SLight, SStart, SFinal, SVsize, SPw, SDone, SPerr, SFare} sel_e;

  typedef struct {
    string      name;
    sel_e       sel;
    logic [9:0] exp;
  } sb_t;

  typedef struct {
    string      name;
    logic       tk, ci, at, lv;
    logic [2:0] sz;
    logic [3:0] pn;
    sel_e       sel;
    logic [9:0] exp;
  } vec_t;

  sb_t sb[$];

  function automatic logic [9:0] get(input sel_e s);
    case (s)
      SOcc:    return {9'd0, occupied};
      SLight:  return light;
      SStart:  return {1'b0, start_time};
      SFinal:  return {1'b0, final_time};
      SVsize:  return {7'd0, vehicle_size_out};
      SPw:     return {9'd0, password_correct};
      SDone:   return {9'd0, car_in_done};
      SPerr:   return {9'd0, pin_error};
      default: return {9'd0, calculate_fare};
    endcase
  endfunction

  task automatic want(input string n, input sel_e s, input logic [9:0] v);
    sb.push_back('{n, s, v});
  endtask

  task automatic compare_all();
    sb_t e;
    logic [9:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = get(e.sel);
      n_vec++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s (%s): got %h want %h", e.name, e.sel.name(), act, e.exp);
      end
    end
  endtask

  task automatic drive(input logic tk, ci, at, lv, input logic [2:0] sz, input logic [3:0] pn);
    tick = tk; car_in = ci; attempt = at; leave = lv; vehicle_size = sz; pin = pn;
  endtask

  // Apply inputs for exactly one clock, then check queued expectations.
  task automatic step(input logic tk, ci, at, lv, input logic [2:0] sz, input logic [3:0] pn);
    drive(tk, ci, at, lv, sz, pn);
    @(posedge clock);
    #1;
    compare_all();
    drive(0, 0, 0, 0, 3'b000, 4'h0);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    drive(0, 0, 0, 0, 3'b000, 4'h0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  localparam int NV = 13;
  vec_t tbl[NV];
  logic [8:0] dur;

  initial begin
    tbl[0]  = '{"inv_size",     0, 1, 0, 0, 3'b011, 4'hA, SOcc,   10'h000};
    tbl[1]  = '{"inv_size_vs",  0, 0, 0, 0, 3'b000, 4'h0, SVsize, 10'h000};
    tbl[2]  = '{"pre_tick",     1, 0, 0, 0, 3'b000, 4'h0, SLight, 10'h000};
    tbl[3]  = '{"pre_tick",     1, 0, 0, 0, 3'b000, 4'h0, SLight, 10'h000};
    tbl[4]  = '{"pre_tick",     1, 0, 0, 0, 3'b000, 4'h0, SOcc,   10'h000};
    tbl[5]  = '{"pre_tick",     1, 0, 0, 0, 3'b000, 4'h0, SLight, 10'h000};
    tbl[6]  = '{"pre_tick",     1, 0, 0, 0, 3'b000, 4'h0, SOcc,   10'h000};
    tbl[7]  = '{"park",         0, 1, 0, 0, 3'b010, 4'hA, SOcc,   10'h001};
    tbl[8]  = '{"park_start",   0, 0, 0, 0, 3'b000, 4'h0, SStart, 10'd5};
    tbl[9]  = '{"park_light",   0, 0, 0, 0, 3'b000, 4'h0, SLight, 10'h001};
    tbl[10] = '{"park_vsize",   0, 0, 0, 0, 3'b000, 4'h0, SVsize, 10'h002};
    tbl[11] = '{"leave_park",   0, 0, 0, 1, 3'b000, 4'h0, SLight, 10'h001};
    tbl[12] = '{"attempt_park", 0, 0, 1, 0, 3'b000, 4'hA, SPw,    10'h000};

    drive(0, 0, 0, 0, 3'b000, 4'h0);
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    want("rst_occ", SOcc, 0);     want("rst_light", SLight, 0);
    want("rst_start", SStart, 0); want("rst_final", SFinal, 0);
    want("rst_vsize", SVsize, 0); want("rst_pw", SPw, 0);
    want("rst_done", SDone, 0);   want("rst_fare", SFare, 0);
    compare_all();
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      want(tbl[i].name, tbl[i].sel, tbl[i].exp);
      step(tbl[i].tk, tbl[i].ci, tbl[i].at, tbl[i].lv, tbl[i].sz, tbl[i].pn);
    end

    // Park-in walk 001 -> 200, then done pulse on the 10th tick.
    for (int k = 1; k < 10; k++) begin
      want("park_walk", SLight, 10'h001 << k);
      want("park_nodone", SDone, 0);
      step(1, 0, 0, 0, 3'b000, 4'h0);
    end
    want("park_done", SDone, 1); want("occ_light", SLight, 10'h3FF);
    step(1, 0, 0, 0, 3'b000, 4'h0);
    want("done_pulse", SDone, 0); want("occ_occ", SOcc, 1);
    step(0, 0, 0, 0, 3'b000, 4'h0);

    want("leave_occ_light", SLight, 10'h3FF); want("leave_occ_fare", SFare, 0);
    step(0, 0, 0, 1, 3'b000, 4'h0);

    want("bad_pin_err", SPerr, 1); want("bad_pin_pw", SPw, 0);
    want("bad_pin_light", SLight, 10'h3FF);
    step(0, 0, 1, 0, 3'b000, 4'h3);
    want("perr_pulse", SPerr, 0);
    step(0, 0, 0, 0, 3'b000, 4'h0);

    want("good_fare", SFare, 1); want("good_pw", SPw, 1);
    want("good_final", SFinal, 10'd15); want("bill_light", SLight, 10'h155);
    step(0, 0, 1, 0, 3'b000, 4'hA);
    want("fare_pulse", SFare, 0); want("bill_pw", SPw, 1);
    step(0, 0, 0, 0, 3'b000, 4'h0);
    want("bill_attempt_final", SFinal, 10'd15); want("bill_attempt_fare", SFare, 0);
    step(1, 0, 1, 0, 3'b000, 4'hA);
    want("bill_carin_vsize", SVsize, 10'h002); want("bill_carin_start", SStart, 10'd5);
    step(0, 1, 0, 0, 3'b001, 4'h5);

    want("depart_light", SLight, 10'h200); want("depart_occ", SOcc, 1);
    step(0, 0, 0, 1, 3'b000, 4'h0);
    for (int k = 1; k < 10; k++) begin
      want("depart_walk", SLight, 10'h200 >> k);
      want("depart_occ", SOcc, 1);
      step(1, 0, 0, 0, 3'b000, 4'h0);
    end
    want("empty_occ", SOcc, 0); want("empty_light", SLight, 0);
    want("empty_pw", SPw, 0);   want("empty_vsize", SVsize, 0);
    step(1, 0, 0, 0, 3'b000, 4'h0);
    want("hold_final", SFinal, 10'd15); want("hold_start", SStart, 10'd5);
    step(0, 0, 0, 0, 3'b000, 4'h0);

    // Wrap-around: park at 508, pick up at 6; car_in beats attempt in EMPTY.
    apply_reset();
    repeat (508) step(1, 0, 0, 0, 3'b000, 4'h0);
    want("wrap_start", SStart, 10'd508); want("wrap_occ", SOcc, 1);
    want("carin_wins_pw", SPw, 0);
    step(0, 1, 1, 0, 3'b100, 4'h7);
    repeat (9) step(1, 0, 0, 0, 3'b000, 4'h0);
    want("wrap_done", SDone, 1);
    step(1, 0, 0, 0, 3'b000, 4'h0);
    want("wrap_final", SFinal, 10'd6); want("wrap_pw", SPw, 1);
    step(1, 0, 1, 0, 3'b000, 4'h7);
    dur = final_time - start_time;
    n_vec++;
    if (dur !== 9'd10) begin
      n_err++;
      $display("FAIL wrap_duration: got %0d want 10", dur);
    end

    // Reset mid-animation abandons the park.
    apply_reset();
    want("mid_park", SOcc, 1);
    step(0, 1, 0, 0, 3'b001, 4'h1);
    for (int k = 1; k <= 4; k++) begin
      want("mid_walk", SLight, 10'h001 << k);
      step(1, 0, 0, 0, 3'b000, 4'h0);
    end
    #2;
    resetn = 1'b0;
    #1;
    want("mid_rst_occ", SOcc, 0);     want("mid_rst_light", SLight, 0);
    want("mid_rst_vsize", SVsize, 0); want("mid_rst_start", SStart, 0);
    want("mid_rst_final", SFinal, 0); want("mid_rst_done", SDone, 0);
    compare_all();
    @(posedge clock);
    #1;
    resetn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      want("post_rst_nodone", SDone, 0);
      want("post_rst_occ", SOcc, 0);
      step(1, 0, 0, 0, 3'b000, 4'h0);
    end
    want("post_rst_counter", SStart, 10'd12);
    step(0, 1, 0, 0, 3'b001, 4'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
